fb_access_arbiter: RTL and testbench

- Shares one single-port 8-bit image framebuffer between two requesters: the VGA display read path and a host port (image loader / processing engine).
- The display path has priority; a wait counter guarantees host progress.
- Converts display (x,y) coordinates to a linear address and drives the memory's enable, write-enable, address and data signals.
- Sits between the VGA timing/pixel logic and the frame-buffer RAM, in the CLOCK_50 domain.

---
 rtl/fb_access_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_fb_access_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Framebuffer access arbiter: shares one single-port pixel RAM between the
// VGA display read path (priority) and a host read/write port. A wait counter
// bounds host starvation by force-granting the host after HOST_MAX_WAIT
// consecutive denied cycles.
//
// Ports:
//   CLOCK_50, RESET             clock, synchronous active-high reset
//   disp_req/x/y                display read request and pixel coordinates
//   disp_valid/data/miss        display response (2 cycles after sampling)
//   host_req/we/addr/wdata      host request, held until host_ack
//   host_ack/rdata/err          host completion (2 cycles after grant)
//   mem_en/we/addr/wdata        registered RAM controls
//   mem_rdata                   RAM read data, 1-cycle latency
module fb_access_arbiter #(
  parameter int unsigned IMG_W         = 240,
  parameter int unsigned IMG_H         = 320,
  parameter int unsigned ADDR_W        = 17,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned HOST_MAX_WAIT = 4
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_miss,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W   = $clog2(HOST_MAX_WAIT + 1);
  localparam int unsigned IMG_PIX = IMG_W * IMG_H;

  typedef enum logic [1:0] {H_IDLE, H_GRANT, H_ACK} hstate_e;

  hstate_e             hstate_q, hstate_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  // Stage 1: grant edge -> RAM access cycle; stage 2: RAM read edge -> response
  logic s1_disp_q, s1_disp_d, s1_disp_rd_q, s1_disp_rd_d, s1_miss_q, s1_miss_d;
  logic s1_host_q, s1_host_d, s1_host_rd_q, s1_host_rd_d, s1_herr_q, s1_herr_d;
  logic s2_disp_q, s2_disp_d, s2_disp_rd_q, s2_disp_rd_d, s2_miss_q, s2_miss_d;
  logic s2_host_q, s2_host_d, s2_host_rd_q, s2_host_rd_d, s2_herr_q, s2_herr_d;

  logic                disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_miss_q, disp_miss_d;
  logic [DATA_W-1:0]   last_pix_q, last_pix_d;
  logic                host_ack_q, host_ack_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                host_err_q, host_err_d;

  logic                disp_in_rng, host_in_rng, host_pend, host_forced;
  logic                host_win, disp_win;
  logic [ADDR_W-1:0]   disp_addr;

  // Arbitration, host FSM, request pipeline and response formatting
  always_comb begin
    disp_in_rng = (disp_x < 10'(IMG_W)) && (disp_y < 10'(IMG_H));
    host_in_rng = 32'(host_addr) < IMG_PIX;
    disp_addr   = ADDR_W'(disp_y) * ADDR_W'(IMG_W) + ADDR_W'(disp_x);
    host_pend   = host_req && (hstate_q == H_IDLE);
    host_forced = wait_cnt_q == CNT_W'(HOST_MAX_WAIT);
    host_win    = host_pend && (!disp_req || host_forced);
    disp_win    = disp_req && !host_win;

    hstate_d     = hstate_q;
    wait_cnt_d   = wait_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    // Every display request gets a response; a lost arbitration is a miss
    s1_disp_d    = disp_req;
    s1_disp_rd_d = 1'b0;
    s1_miss_d    = disp_req && host_win;
    s1_host_d    = host_win;
    s1_host_rd_d = 1'b0;
    s1_herr_d    = 1'b0;
    s2_disp_d    = s1_disp_q;
    s2_disp_rd_d = s1_disp_rd_q;
    s2_miss_d    = s1_miss_q;
    s2_host_d    = s1_host_q;
    s2_host_rd_d = s1_host_rd_q;
    s2_herr_d    = s1_herr_q;

    disp_valid_d = s2_disp_q;
    disp_miss_d  = s2_miss_q;
    disp_data_d  = s2_disp_rd_q ? mem_rdata : (s2_miss_q ? last_pix_q : '0);
    last_pix_d   = s2_disp_rd_q ? mem_rdata : last_pix_q;
    host_ack_d   = s2_host_q;
    host_rdata_d = s2_host_rd_q ? mem_rdata : '0;
    host_err_d   = s2_herr_q;

    // Starvation counter: counts denied idle-state host cycles, saturating
    if (host_win) begin
      wait_cnt_d = '0;
    end else if (host_pend && !host_forced) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end

    unique case (hstate_q)
      H_IDLE:  if (host_win) hstate_d = H_GRANT;
      H_GRANT: hstate_d = H_ACK;
      H_ACK:   hstate_d = H_IDLE;
      default: hstate_d = H_IDLE;
    endcase

    if (disp_win && disp_in_rng) begin
      mem_en_d     = 1'b1;
      mem_addr_d   = disp_addr;
      s1_disp_rd_d = 1'b1;
    end

    if (host_win) begin
      if (host_in_rng) begin
        mem_en_d     = 1'b1;
        mem_we_d     = host_we;
        mem_addr_d   = host_addr;
        mem_wdata_d  = host_we ? host_wdata : '0;
        s1_host_rd_d = !host_we;
      end else begin
        s1_herr_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hstate_q     <= H_IDLE;
      wait_cnt_q   <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      s1_disp_q    <= 1'b0;
      s1_disp_rd_q <= 1'b0;
      s1_miss_q    <= 1'b0;
      s1_host_q    <= 1'b0;
      s1_host_rd_q <= 1'b0;
      s1_herr_q    <= 1'b0;
      s2_disp_q    <= 1'b0;
      s2_disp_rd_q <= 1'b0;
      s2_miss_q    <= 1'b0;
      s2_host_q    <= 1'b0;
      s2_host_rd_q <= 1'b0;
      s2_herr_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      disp_miss_q  <= 1'b0;
      last_pix_q   <= '0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      host_err_q   <= 1'b0;
    end else begin
      hstate_q     <= hstate_d;
      wait_cnt_q   <= wait_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      s1_disp_q    <= s1_disp_d;
      s1_disp_rd_q <= s1_disp_rd_d;
      s1_miss_q    <= s1_miss_d;
      s1_host_q    <= s1_host_d;
      s1_host_rd_q <= s1_host_rd_d;
      s1_herr_q    <= s1_herr_d;
      s2_disp_q    <= s2_disp_d;
      s2_disp_rd_q <= s2_disp_rd_d;
      s2_miss_q    <= s2_miss_d;
      s2_host_q    <= s2_host_d;
      s2_host_rd_q <= s2_host_rd_d;
      s2_herr_q    <= s2_herr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      disp_miss_q  <= disp_miss_d;
      last_pix_q   <= last_pix_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      host_err_q   <= host_err_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign disp_miss  = disp_miss_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign host_err   = host_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed testbench for fb_access_arbiter with a synchronous-read RAM model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fb_access_arbiter;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic        disp_valid, disp_miss;
  logic [7:0]  disp_data;
  logic        host_req, host_we;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack, host_err;
  logic [7:0]  host_rdata;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  logic [7:0]  ram [0:76799];

  int checks = 0;
  int errors = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  fb_access_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .disp_req   (disp_req),
    .disp_x     (disp_x),
    .disp_y     (disp_y),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_miss  (disp_miss),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .host_err   (host_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous RAM, 1-cycle read latency; preload values applied during reset
  always @(posedge CLOCK_50) begin
    if (RESET) begin
      ram[0]     <= 8'h11;
      ram[76799] <= 8'h22;
      ram[241]   <= 8'h33;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic nclk();
    @(negedge CLOCK_50);
  endtask

  initial begin
    RESET = 1'b1; disp_req = 1'b0; disp_x = '0; disp_y = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) nclk();
    check("rst_disp_valid", 32'(disp_valid), 32'h0);
    check("rst_host_ack",   32'(host_ack),   32'h0);
    check("rst_mem_en",     32'(mem_en),     32'h0);
    check("rst_mem_addr",   32'(mem_addr),   32'h0);
    RESET = 1'b0;

    // Display reads at (0,0) and (239,319)
    disp_req = 1'b1; disp_x = 10'd0; disp_y = 10'd0;
    nclk();
    check("d0_mem_en",   32'(mem_en),   32'h1);
    check("d0_mem_addr", 32'(mem_addr), 32'h0);
    disp_x = 10'd239; disp_y = 10'd319;
    nclk();
    check("d1_mem_addr",  32'(mem_addr),   32'd76799);
    check("d0_not_early", 32'(disp_valid), 32'h0);
    disp_req = 1'b0;
    nclk();
    check("d0_valid", 32'(disp_valid), 32'h1);
    check("d0_data",  32'(disp_data),  32'h11);
    nclk();
    check("d1_valid", 32'(disp_valid), 32'h1);
    check("d1_data",  32'(disp_data),  32'h22);
    check("d1_miss",  32'(disp_miss),  32'h0);

    // Out-of-range display coordinate
    disp_req = 1'b1; disp_x = 10'd240; disp_y = 10'd5;
    nclk();
    check("oor_mem_en", 32'(mem_en), 32'h0);
    disp_req = 1'b0;
    nclk();
    nclk();
    check("oor_valid", 32'(disp_valid), 32'h1);
    check("oor_data",  32'(disp_data),  32'h0);
    check("oor_miss",  32'(disp_miss),  32'h0);

    // Host write then read of address 100
    host_req = 1'b1; host_we = 1'b1; host_addr = 17'd100; host_wdata = 8'hA5;
    nclk();
    check("hw_mem_en",    32'(mem_en),    32'h1);
    check("hw_mem_we",    32'(mem_we),    32'h1);
    check("hw_mem_addr",  32'(mem_addr),  32'd100);
    check("hw_mem_wdata", 32'(mem_wdata), 32'hA5);
    nclk();
    check("hw_we_1cyc",   32'(mem_we),    32'h0);
    check("hw_ack_early", 32'(host_ack),  32'h0);
    nclk();
    check("hw_ack", 32'(host_ack), 32'h1);
    check("hw_err", 32'(host_err), 32'h0);
    host_we = 1'b0; host_wdata = 8'h00;
    nclk();
    check("hw_ack_pulse", 32'(host_ack), 32'h0);
    check("hr_mem_we",    32'(mem_we),   32'h0);
    nclk();
    nclk();
    check("hr_ack",   32'(host_ack),   32'h1);
    check("hr_rdata", 32'(host_rdata), 32'hA5);

    // Display held high at (1,1) with a host read pending: forced grant
    disp_req = 1'b1; disp_x = 10'd1; disp_y = 10'd1;
    repeat (4) nclk();
    check("fg_disp_addr", 32'(mem_addr), 32'd241);
    nclk();
    check("fg_host_en",   32'(mem_en),   32'h1);
    check("fg_host_addr", 32'(mem_addr), 32'd100);
    nclk();
    check("fg_pre_valid", 32'(disp_valid), 32'h1);
    check("fg_pre_miss",  32'(disp_miss),  32'h0);
    check("fg_pre_data",  32'(disp_data),  32'h33);
    nclk();
    check("fg_miss_valid", 32'(disp_valid), 32'h1);
    check("fg_miss",       32'(disp_miss),  32'h1);
    check("fg_miss_data",  32'(disp_data),  32'h33);
    check("fg_host_ack",   32'(host_ack),   32'h1);
    check("fg_host_rdata", 32'(host_rdata), 32'hA5);

    // Host address out of range
    disp_req = 1'b0; host_addr = 17'd76800;
    nclk();
    check("herr_mem_en0", 32'(mem_en), 32'h0);
    nclk();
    check("herr_mem_en1", 32'(mem_en), 32'h0);
    nclk();
    check("herr_ack",   32'(host_ack),   32'h1);
    check("herr_err",   32'(host_err),   32'h1);
    check("herr_rdata", 32'(host_rdata), 32'h0);

    // Reset during H_GRANT of a host read, then the held request completes
    host_addr = 17'd100;
    nclk();
    check("rg_mem_en", 32'(mem_en), 32'h1);
    RESET = 1'b1;
    nclk();
    check("rg_rst_ack",   32'(host_ack),   32'h0);
    check("rg_rst_mem",   32'(mem_en),     32'h0);
    check("rg_rst_valid", 32'(disp_valid), 32'h0);
    RESET = 1'b0;
    nclk();
    check("rg_no_ack0", 32'(host_ack), 32'h0);
    nclk();
    check("rg_no_ack1", 32'(host_ack), 32'h0);
    nclk();
    check("rg_ack",   32'(host_ack),   32'h1);
    check("rg_rdata", 32'(host_rdata), 32'hA5);
    check("rg_err",   32'(host_err),   32'h0);
    host_req = 1'b0;
    nclk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
